multibyte_add_seq: RTL

- Sequencer that drives the 8-bit ALU adder over multi-byte operands, one byte per cycle, least significant byte first.
- Supports ADD, ADC, SUB and SBC across 1..MAX_BYTES bytes.
- Selects the adder carry-in and chains the carry between bytes.
- Buffers each result byte behind a valid/ready output stage.
- Sits between the multi-byte instruction issue logic and the adder; the adder is instantiated alongside this block at the ALU level.

---
 rtl/jam_alu_pkg.sv | 30 +++
 rtl/byte_out_stage.sv | 28 ++
 rtl/multibyte_add_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/jam_alu_pkg.sv
// Shared encodings for the multi-byte ALU sequencer: opcodes, adder carry
// selects and sequencer states.
package jam_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } opE;

    // Carry select is {CarrySelectB, CarrySelectA} on the adder.
    typedef enum logic [1:0] {
        CSEL_ZERO = 2'b00,
        CSEL_ONE  = 2'b01,
        CSEL_FLAG = 2'b10
    } cselE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10
    } stateE;

    // SUB and SBC feed the inverted RHS to the adder.
    function automatic logic isSubtract(input opE o);
        return o[1];
    endfunction

endpackage

// File: rtl/byte_out_stage.sv
// One-entry valid/ready register holding the most recent result byte.
module byte_out_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] loadData,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    // Load wins over drain; clear (abort) wins over both. Data only changes on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= loadData;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial sequencer for the 8-bit ALU adder: ADD/ADC/SUB/SBC over
// 1..MAX_BYTES bytes, LSB first, carry chained between bytes.
// Optional feature: define MULTIBYTE_OVF_EN to add the ovf_out port.
module multibyte_add_seq
    import jam_alu_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    localparam int unsigned CW = $clog2(MAX_BYTES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [CW-1:0] byte_count,
    input  logic          flag_c_in,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [7:0]    in_lhs,
    input  logic [7:0]    in_rhs,
    output logic          in_ready,
    output logic [7:0]    adder_lhs,
    output logic [7:0]    adder_rhs,
    output logic          adder_carry_flag,
    output logic          carry_sel_a,
    output logic          carry_sel_b,
    input  logic [7:0]    adder_out,
    input  logic          adder_carry_out,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          carry_out,
    output logic          zero_out,
`ifdef MULTIBYTE_OVF_EN
    output logic          ovf_out,
`endif
    output logic          err
);

    stateE         state;
    opE            opReg;
    logic [CW-1:0] countReg;
    logic [CW-1:0] byteIdx;
    logic          chainCarry;
    logic          runZero;
    cselE          cselC;
    logic          accept;
    logic          firstByte;
    logic          lastByte;
    logic          countLegal;

    assign firstByte  = (byteIdx == '0);
    assign lastByte   = (byteIdx == CW'(countReg - CW'(1)));
    assign countLegal = (byte_count != '0) && (byte_count <= CW'(MAX_BYTES));
    assign in_ready   = (state == S_RUN) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready && !abort;

    // Adder operand and carry-in steering; quiet (all zero) outside RUN.
    always_comb begin
        cselC            = CSEL_ZERO;
        adder_carry_flag = 1'b0;
        adder_lhs        = 8'h00;
        adder_rhs        = 8'h00;
        if (state == S_RUN) begin
            adder_lhs = in_lhs;
            adder_rhs = isSubtract(opReg) ? ~in_rhs : in_rhs;
            if (firstByte) begin
                case (opReg)
                    OP_ADD:  cselC = CSEL_ZERO;
                    OP_SUB:  cselC = CSEL_ONE;
                    default: begin
                        cselC            = CSEL_FLAG;
                        adder_carry_flag = flag_c_in;
                    end
                endcase
            end else begin
                cselC            = CSEL_FLAG;
                adder_carry_flag = chainCarry;
            end
        end
    end

    assign carry_sel_a = cselC[0];
    assign carry_sel_b = cselC[1];

    // Sequencer FSM with registered status, flags and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            opReg      <= OP_ADD;
            countReg   <= '0;
            byteIdx    <= '0;
            chainCarry <= 1'b0;
            runZero    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            carry_out  <= 1'b0;
            zero_out   <= 1'b0;
`ifdef MULTIBYTE_OVF_EN
            ovf_out    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (countLegal) begin
                            opReg      <= opE'(op);
                            countReg   <= byte_count;
                            byteIdx    <= '0;
                            chainCarry <= 1'b0;
                            runZero    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (accept) begin
                        chainCarry <= adder_carry_out;
                        runZero    <= runZero && (adder_out == 8'h00);
                        byteIdx    <= CW'(byteIdx + CW'(1));
                        if (lastByte) begin
                            carry_out <= adder_carry_out;
                            zero_out  <= runZero && (adder_out == 8'h00);
`ifdef MULTIBYTE_OVF_EN
                            ovf_out   <= (adder_lhs[7] == adder_rhs[7]) &&
                                         (adder_out[7] != adder_lhs[7]);
`endif
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (out_valid && out_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    byte_out_stage uOutStage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .clear     (abort && (state != S_IDLE)),
        .loadData  (adder_out),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
